avalon_led_out_pio: RTL and testbench

//   Avalon-MM slave output PIO driving board LEDs; write-side counterpart of the switch input PIO.
//   CPU writes a data register, atomic bit set/clear aliases, and a per-bit blink mask.
//   A shared prescaler toggles the masked bits at a programmable rate.

---
 rtl/avalon_led_out_pio.sv | 97 +++++++++
 tb/tb_avalon_led_out_pio.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/avalon_led_out_pio.sv
// avalon_led_out_pio: Avalon-MM output PIO driving board LEDs, with set/clear aliases and optional blink.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous, active-low reset
//   address    register word address (0 DATA, 1 MASK, 2 PERIOD, 4 OUTSET, 5 OUTCLR)
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  write data; bits above WIDTH / CNT_W ignored
//   readdata   registered read data, zero-extended, one-cycle latency
//   out_port   LED drive
//
// Build option: define LED_PIO_BLINK_EN to include the MASK/PERIOD registers and the
// blink prescaler. Without it, addresses 1 and 2 are reserved and out_port is data_reg.
module avalon_led_out_pio #(
    parameter int               WIDTH       = 18,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               CNT_W       = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);
    logic             we;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data_reg;
    logic [31:0]      rd_mux;
    logic             unused_wd;

    assign we        = chipselect & ~write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            data_reg <= RESET_VALUE;
        else if (we)
            data_reg <= address == 3'd0 ? wd :
                        address == 3'd4 ? data_reg | wd :
                        address == 3'd5 ? data_reg & ~wd : data_reg;

`ifdef LED_PIO_BLINK_EN
    logic [WIDTH-1:0] blink_mask;
    logic [CNT_W-1:0] period_reg;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] pw;
    logic             phase;
    logic             per_we;

    assign pw     = writedata[CNT_W-1:0];
    assign per_we = we && address == 3'd2;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            blink_mask <= '0;
            period_reg <= '0;
            cnt        <= '0;
            phase      <= 1'b0;
        end else begin
            if (we && address == 3'd1)
                blink_mask <= wd;
            if (per_we)
                period_reg <= pw;
            // A PERIOD write restarts the countdown at the new rate; writing 0 halts
            // blinking straight away so masked bits fall back to data_reg next cycle.
            cnt   <= per_we ? (pw == '0 ? '0 : pw - 1'b1) :
                     period_reg == '0 ? '0 :
                     cnt == '0 ? period_reg - 1'b1 : cnt - 1'b1;
            phase <= per_we ? (pw == '0 ? 1'b0 : phase) :
                     period_reg == '0 ? 1'b0 :
                     cnt == '0 ? ~phase : phase;
        end

    assign out_port = data_reg ^ (blink_mask & {WIDTH{phase}});

    always_comb
        rd_mux = address == 3'd0 ? 32'(data_reg) :
                 address == 3'd1 ? 32'(blink_mask) :
                 address == 3'd2 ? 32'(period_reg) : 32'd0;
`else
    assign out_port = data_reg;

    always_comb
        rd_mux = address == 3'd0 ? 32'(data_reg) : 32'd0;
`endif

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            readdata <= '0;
        else
            readdata <= rd_mux;
endmodule

// File: tb/tb_avalon_led_out_pio.sv
// tb_avalon_led_out_pio: randomized self-checking bench for avalon_led_out_pio against a register-map model.
module tb_avalon_led_out_pio;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [17:0] out_port;

    int checks = 0;
    int failures = 0;

    logic [17:0] m_data = '0;
    logic [17:0] m_mask = '0;
    logic [23:0] m_period = '0;

    avalon_led_out_pio dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_read(input logic [2:0] a);
        exp_read = a == 3'd0 ? 32'(m_data) : 32'd0;
`ifdef LED_PIO_BLINK_EN
        if (a == 3'd1) exp_read = 32'(m_mask);
        if (a == 3'd2) exp_read = 32'(m_period);
`endif
    endfunction

    // Drive one bus cycle; returns on the falling edge right after the sampling edge.
    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic cs = 1'b1, input logic wn = 1'b0);
        @(negedge clk);
        address = a; writedata = d; chipselect = cs; write_n = wn;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
        if (cs && !wn) begin
            if (a == 3'd0) m_data = d[17:0];
            if (a == 3'd4) m_data = m_data | d[17:0];
            if (a == 3'd5) m_data = m_data & ~d[17:0];
`ifdef LED_PIO_BLINK_EN
            if (a == 3'd1) m_mask = d[17:0];
            if (a == 3'd2) m_period = d[23:0];
`endif
        end
    endtask

    task automatic rd_check(input logic [2:0] a, input string name);
        @(negedge clk);
        address = a;
        @(negedge clk);
        checks++;
        if (readdata !== exp_read(a)) begin
            failures++;
            $display("FAIL %s addr=%0d readdata=%h expected=%h", name, a, readdata, exp_read(a));
        end
    endtask

    task automatic out_check(input logic [17:0] exp, input string name);
        checks++;
        if (out_port !== exp) begin
            failures++;
            $display("FAIL %s out_port=%h expected=%h", name, out_port, exp);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        m_data = '0; m_mask = '0; m_period = '0;
        out_check(18'h0, "reset_out");
        rd_check(3'd0, "reset_read_data");
        rd_check(3'd1, "reset_read_mask");
        rd_check(3'd2, "reset_read_period");
    endtask

    task automatic test_set_clear;
        wr(3'd0, 32'h3FFFF);
        wr(3'd5, 32'h0000F);
        wr(3'd4, 32'h00100);
        out_check(18'h3FFF0, "setclr_out");
        checks++;
        if (m_data !== 18'h3FFF0) begin
            failures++;
            $display("FAIL setclr_model model=%h expected=3fff0", m_data);
        end
        rd_check(3'd0, "setclr_read");
    endtask

    task automatic test_reserved;
        wr(3'd0, 32'h0A5A5);
        wr(3'd6, 32'hFFFF);
        wr(3'd0, 32'hFFFF, 1'b0, 1'b0);
        wr(3'd0, 32'hFFFF, 1'b1, 1'b1);
        wr(3'd3, 32'hFFFF);
        wr(3'd7, 32'hFFFF);
        out_check(18'h0A5A5, "reserved_out");
        rd_check(3'd0, "reserved_data");
        rd_check(3'd4, "reserved_read4");
        rd_check(3'd5, "reserved_read5");
        rd_check(3'd6, "reserved_read6");
        rd_check(3'd3, "reserved_read3");
        rd_check(3'd7, "reserved_read7");
`ifndef LED_PIO_BLINK_EN
        wr(3'd1, 32'h3FFFF);
        wr(3'd2, 32'h1);
        repeat (3) @(negedge clk);
        out_check(18'h0A5A5, "noblink_out");
        rd_check(3'd1, "noblink_mask");
        rd_check(3'd2, "noblink_period");
`endif
    endtask

    // Random writes to every address except PERIOD, so the output stays unblinked.
    task automatic test_random;
        logic [2:0] a;
        logic [31:0] d;
        for (int i = 0; i < 40; i++) begin
            a = 3'($urandom_range(0, 7));
            if (a == 3'd2) a = 3'd4;
            d = $urandom;
            wr(a, d, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0));
            out_check(m_data, "random_out");
            if (i % 4 == 0) rd_check(3'($urandom_range(0, 7)), "random_read");
        end
        rd_check(3'd0, "random_final_data");
        rd_check(3'd1, "random_final_mask");
    endtask

`ifdef LED_PIO_BLINK_EN
    // Phase after k edges since a PERIOD write (from a halted, phase-0 state) is (k / P) mod 2.
    task automatic blink_run(input logic [17:0] d, input logic [17:0] m, input int p, input int edges, input string name);
        logic [17:0] exp;
        wr(3'd2, 32'd0);
        wr(3'd0, 32'(d));
        wr(3'd1, 32'(m));
        wr(3'd2, 32'(p));
        for (int k = 0; k <= edges; k++) begin
            exp = ((k / p) % 2 == 1) ? (m_data ^ m_mask) : m_data;
            out_check(exp, name);
            @(negedge clk);
        end
    endtask

    task automatic test_blink;
        blink_run(18'h1, 18'h3, 4, 17, "blink_p4");
        rd_check(3'd2, "blink_read_period");
        rd_check(3'd1, "blink_read_mask");
        blink_run(18'h2AAAA, 18'h3FFFF, 1, 6, "blink_p1");
        for (int i = 0; i < 3; i++)
            blink_run(18'($urandom), 18'($urandom), $urandom_range(2, 6), 14, "blink_rand");
    endtask

    task automatic test_period_zero;
        blink_run(18'h1, 18'h3, 3, 4, "halt_pre");
        wr(3'd2, 32'd0);
        for (int k = 0; k < 6; k++) begin
            out_check(18'h1, "halt_steady");
            @(negedge clk);
        end
        rd_check(3'd2, "halt_read_period");
    endtask
`endif

    task automatic test_async_reset;
        wr(3'd0, 32'h15);
`ifdef LED_PIO_BLINK_EN
        wr(3'd1, 32'h3);
        wr(3'd2, 32'd2);
`endif
        address = 3'd0;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        out_check(18'h0, "async_out");
        checks++;
        if (readdata !== 32'd0) begin
            failures++;
            $display("FAIL async_readdata readdata=%h expected=0", readdata);
        end
        m_data = '0; m_mask = '0; m_period = '0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        out_check(18'h0, "post_reset_out");
        rd_check(3'd0, "post_reset_data");
        rd_check(3'd2, "post_reset_period");
    endtask

    initial begin
        test_reset();
        test_set_clear();
        test_reserved();
        test_random();
`ifdef LED_PIO_BLINK_EN
        test_blink();
        test_period_zero();
`endif
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
